// File: rtl/sata_rx_dword_aligner.sv
// SATA receive dword aligner: finds the K28.5 lane of ALIGN primitives and barrel-shifts the stream to byte 0.
// Optional macro SATA_RX_ALIGN_DROP_EN: deassert al_valid on ALIGN dwords while locked.
module sata_rx_dword_aligner #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 8
) (
    input  logic        reset,
    input  logic        clk,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_datak,
    input  logic [3:0]  rx_patterndetect,
    input  logic [3:0]  rx_syncstatus,
    input  logic        rx_is_lockedtodata,
    output logic [31:0] al_data,
    output logic [3:0]  al_datak,
    output logic        al_valid,
    output logic        al_aligned,
    output logic [1:0]  al_offset,
    output logic        al_align_det
);

    localparam logic [31:0] ALIGN_DATA = 32'h7B4A4ABC;
    localparam logic [3:0]  ALIGN_K    = 4'b0001;
    localparam logic [3:0]  LOCK_CNT   = 4'(LOCK_COUNT);
    localparam logic [7:0]  LOSS_CNT   = 8'(LOSS_COUNT);

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_t;

    state_t      state, state_next;
    logic [31:0] prev_data;
    logic [3:0]  prev_datak;
    logic [1:0]  offset_next;
    logic [3:0]  cnt, cnt_next;
    logic [7:0]  errcnt, errcnt_next;

    logic [63:0] cat_data;
    logic [7:0]  cat_datak;
    logic [31:0] shifted_data;
    logic [3:0]  shifted_datak;
    logic        aligned_align;
    logic        cand;
    logic [1:0]  cand_lane;
    logic        sync_ok;
    logic        lane_err;
    logic        locked_hold;
    logic        valid_next;
    logic        det_next;

    assign cat_data  = {rx_data, prev_data};
    assign cat_datak = {rx_datak, prev_datak};

    // Bytes k..3 of the previous word followed by bytes 0..k-1 of the current word.
    always_comb begin
        shifted_data  = cat_data[31:0];
        shifted_datak = cat_datak[3:0];
        case (al_offset)
            2'd0: begin
                shifted_data  = cat_data[31:0];
                shifted_datak = cat_datak[3:0];
            end
            2'd1: begin
                shifted_data  = cat_data[39:8];
                shifted_datak = cat_datak[4:1];
            end
            2'd2: begin
                shifted_data  = cat_data[47:16];
                shifted_datak = cat_datak[5:2];
            end
            default: begin
                shifted_data  = cat_data[55:24];
                shifted_datak = cat_datak[6:3];
            end
        endcase
    end

    assign aligned_align = (shifted_data == ALIGN_DATA) && (shifted_datak == ALIGN_K);

    // A comma only counts when exactly one lane reports it and that lane carries a K character.
    always_comb begin
        cand      = 1'b0;
        cand_lane = 2'd0;
        case (rx_patterndetect)
            4'b0001: begin
                cand_lane = 2'd0;
                cand      = rx_datak[0];
            end
            4'b0010: begin
                cand_lane = 2'd1;
                cand      = rx_datak[1];
            end
            4'b0100: begin
                cand_lane = 2'd2;
                cand      = rx_datak[2];
            end
            4'b1000: begin
                cand_lane = 2'd3;
                cand      = rx_datak[3];
            end
            default: begin
                cand_lane = 2'd0;
                cand      = 1'b0;
            end
        endcase
    end

    assign sync_ok  = (rx_syncstatus == 4'hF) && rx_is_lockedtodata;
    assign lane_err = cand && (cand_lane != al_offset);

    always_comb begin
        state_next  = state;
        offset_next = al_offset;
        cnt_next    = cnt;
        errcnt_next = errcnt;
        case (state)
            HUNT: begin
                if (cand && sync_ok) begin
                    offset_next = cand_lane;
                    cnt_next    = 4'd0;
                    state_next  = CHECK;
                end
            end
            CHECK: begin
                if (lane_err || !sync_ok) begin
                    state_next = HUNT;
                end else if (aligned_align) begin
                    cnt_next = cnt + 4'd1;
                    if (cnt_next == LOCK_CNT) begin
                        state_next  = LOCKED;
                        errcnt_next = 8'd0;
                    end
                end
            end
            LOCKED: begin
                // An error in the same cycle as an aligned ALIGN takes precedence over the clear.
                if (lane_err || (rx_syncstatus != 4'hF)) begin
                    if (errcnt < LOSS_CNT) begin
                        errcnt_next = errcnt + 8'd1;
                    end
                end else if (aligned_align) begin
                    errcnt_next = 8'd0;
                end
                if (errcnt_next == LOSS_CNT) begin
                    state_next = HUNT;
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase
        if (!rx_is_lockedtodata) begin
            state_next = HUNT;
        end
    end

    // Valid and aligned drop in the same cycle the FSM decides to leave LOCKED.
    assign locked_hold = (state == LOCKED) && (state_next == LOCKED);
`ifdef SATA_RX_ALIGN_DROP_EN
    assign valid_next = locked_hold && !aligned_align;
`else
    assign valid_next = locked_hold;
`endif
    assign det_next = aligned_align && (state != HUNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HUNT;
            prev_data    <= 32'd0;
            prev_datak   <= 4'd0;
            al_offset    <= 2'd0;
            cnt          <= 4'd0;
            errcnt       <= 8'd0;
            al_data      <= 32'd0;
            al_datak     <= 4'd0;
            al_valid     <= 1'b0;
            al_aligned   <= 1'b0;
            al_align_det <= 1'b0;
        end else begin
            state        <= state_next;
            prev_data    <= rx_data;
            prev_datak   <= rx_datak;
            al_offset    <= offset_next;
            cnt          <= cnt_next;
            errcnt       <= errcnt_next;
            al_data      <= shifted_data;
            al_datak     <= shifted_datak;
            al_valid     <= valid_next;
            al_aligned   <= locked_hold;
            al_align_det <= det_next;
        end
    end

endmodule
